// File: rtl/leaf_packet_injector.sv
// Leaf-to-BFT packet injector: arbitrates NUM_SRC output-stream sources round-robin,
// wraps each word with its configured (leaf, port) destination and holds it until accepted.
module leaf_packet_injector #(
  parameter int unsigned PACKET_BITS   = 97,
  parameter int unsigned NUM_LEAF_BITS = 6,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned SRC_IDX_BITS  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*32-1:0]    src_data,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic                     cfg_wr_en,
  input  logic [SRC_IDX_BITS-1:0]  cfg_src,
  input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic [15:0]              pkt_count
);

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned VLD_BIT   = PACKET_BITS - 1;
  localparam int unsigned PAD_BITS  = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - WORD_BITS;

  logic [NUM_LEAF_BITS-1:0] tbl_leaf [NUM_SRC];
  logic [NUM_PORT_BITS-1:0] tbl_port [NUM_SRC];
  logic [NUM_SRC-1:0]       tbl_dvld;

  logic [SRC_IDX_BITS-1:0]  rr_ptr;
  logic [SRC_IDX_BITS-1:0]  rr_ptr_next;
  logic [NUM_SRC-1:0]       eligible;
  logic [NUM_SRC-1:0]       grant;
  logic [SRC_IDX_BITS-1:0]  grant_idx;
  logic                     found;
  logic                     slot_free;
  logic                     dout_accept;
  logic                     cfg_ok;
  logic [WORD_BITS-1:0]     grant_word;
  logic [PACKET_BITS-1:0]   grant_pkt;
  int unsigned              idx;

  assign slot_free   = !dout_leaf_interface2bft[VLD_BIT] || !resend;
  assign dout_accept = dout_leaf_interface2bft[VLD_BIT] && !resend;
  assign eligible    = src_valid & tbl_dvld;

  // Round-robin search starting at rr_ptr and wrapping; only when the output slot frees up.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (!reset && slot_free) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        idx = (32'(rr_ptr) + k) % NUM_SRC;
        if (!found && eligible[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = SRC_IDX_BITS'(idx);
        end
      end
    end
  end

  assign src_ready   = grant;
  assign rr_ptr_next = (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + SRC_IDX_BITS'(1);
  assign grant_word  = src_data[32'(grant_idx)*WORD_BITS +: WORD_BITS];
  assign grant_pkt   = {1'b1, tbl_leaf[grant_idx], tbl_port[grant_idx], {PAD_BITS{1'b0}}, grant_word};

  // Only ports 2..8 name a real destination; anything else leaves the entry untouched.
  assign cfg_ok = cfg_wr_en && (32'(cfg_src) < NUM_SRC) &&
                  (32'(cfg_port) >= 32'd2) && (32'(cfg_port) <= 32'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_leaf_interface2bft <= '0;
      pkt_count               <= '0;
      rr_ptr                  <= '0;
      tbl_dvld                <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        tbl_leaf[i] <= '0;
        tbl_port[i] <= '0;
      end
    end else begin
      if (found) begin
        dout_leaf_interface2bft <= grant_pkt;
        rr_ptr                  <= rr_ptr_next;
      end else if (dout_accept) begin
        dout_leaf_interface2bft <= '0;
      end
      if (dout_accept) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (cfg_ok) begin
        tbl_leaf[cfg_src] <= cfg_leaf;
        tbl_port[cfg_src] <= cfg_port;
        tbl_dvld[cfg_src] <= 1'b1;
      end
    end
  end

endmodule
